quad_encoder_decoder: RTL and testbench
=======================================

# quad_encoder_decoder

Front-end conditioner for the two paddle rotary encoders, sitting directly upstream of the paddle-movement stage. Synchronises and debounces the four raw encoder pins, decodes each quadrature pair into direction steps and emits single-cycle up/down strobes per player. Those strobes are the only enables the paddle-position logic uses, so every paddle update happens on `clk` instead of on raw pin edges.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles required before a pin level is accepted; legal range 2..255.
- `STEP_DIV`, 1: valid quadrature transitions per emitted strobe; legal values 1, 2, 4.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `enc1a`, `enc1b` in 1 each: raw player-1 encoder pins, asynchronous to `clk`.
- `enc2a`, `enc2b` in 1 each: raw player-2 encoder pins, asynchronous to `clk`.
- `reset_game` in 1: synchronous, level-sensitive clear of the step accumulators.
- `p1_up`, `p1_dn` out 1 each: player-1 step strobes, one `clk` cycle wide.
- `p2_up`, `p2_dn` out 1 each: player-2 step strobes, one `clk` cycle wide.
- `p1_err`, `p2_err` out 1 each: one-cycle pulse on an illegal quadrature transition.

## Operation
- **Per pin:** 2-flop synchroniser feeding a debounce filter.
  - The filter holds `stable` and a counter.
  - While the synchronised level equals `stable`, the counter is cleared to 0.
  - While the levels differ, the counter increments.
  - When the counter reaches `DEBOUNCE_CYCLES-1` and the levels still differ, `stable` takes the new level and the counter clears.
- **Per encoder:** the decoder registers the previous `{a,b}` as `prev` and compares it with the current debounced `{a,b}`.
  - Forward (+1): 00→10, 10→11, 11→01, 01→00. A rising while B is low counts up.
  - Reverse (−1): 00→01, 01→11, 11→10, 10→00.
  - No change: no action.
  - Both bits changed: illegal. The `err` pulse fires, the accumulator clears, no strobe is issued, and `prev` updates.
- **Accumulator:** signed 4-bit.
  - +1 steps increment it and −1 steps decrement it.
  - On reaching `+STEP_DIV`: `up` pulses and the accumulator returns to 0.
  - On reaching `-STEP_DIV`: `dn` pulses and the accumulator returns to 0.
  - `up` and `dn` for one player are never high together.
- **`reset_game` high:**
  - Accumulators clear to 0 and all strobe/err outputs are forced 0.
  - Synchroniser, debounce and `prev` state keep tracking the pins, so no false step appears on release.
- The two encoders are fully independent; simultaneous activity on both produces independent strobes in the same cycle.

## Timing
- **Reset values:**
  - All synchroniser flops, `stable` and `prev`: 0.
  - Debounce counters and accumulators: 0.
  - All six outputs: 0.
- **Latency with `ENC_DEBOUNCE_EN`:** a clean pin change sampled at clock edge 1 produces its strobe registered at edge `DEBOUNCE_CYCLES+3`, with zero tolerance.
- **Latency without `ENC_DEBOUNCE_EN`:** the strobe is registered at edge 3.
- **Glitches:** a glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles produces no strobe and no err.
- **`reset` mid-operation:** all state returns to reset values immediately and asynchronously.
  - If pins are non-zero on release, the first accepted levels are decoded against `prev`=00.
  - One 00→11 mismatch therefore yields one err pulse, which is the required behaviour.
- **Strobe rate:** at most one strobe per player per `clk` cycle. Back-to-back strobes are legal when `STEP_DIV`=1 and debounce is compiled out.

## Configuration
- **`ENC_DEBOUNCE_EN` defined:** debounce filters are present and `DEBOUNCE_CYCLES` is honoured.
- **`ENC_DEBOUNCE_EN` undefined:**
  - `stable` is the second synchroniser flop directly.
  - The counters are not built and `DEBOUNCE_CYCLES` is ignored.
  - Decode and accumulation are unchanged.

## Structure
- **Shared package `pong_pkg`:**
  - `quad_t`: 2-bit `{a,b}`.
  - Direction encoding constants `DIR_NONE`, `DIR_UP`, `DIR_DN`, `DIR_ERR`.
  - The forward-transition lookup.
  - The `STEP_DIV` legality check.
- **Sub-module `quad_channel`:** synchroniser + debounce + decoder + accumulator for one encoder pair, instantiated twice. The top level only wires pins, `reset_game` and outputs.

## Test plan
- **Forward sequence:** debounce on, `DEBOUNCE_CYCLES`=4, `STEP_DIV`=1. Drive enc1 through 00→10→11→01→00, each level held 10 cycles → exactly 4 `p1_up` pulses, each 7 edges after its pin change, and no `p1_dn`.
- **Divided reverse sequence:** `STEP_DIV`=4. A full reverse cycle on enc2 → exactly one `p2_dn` pulse, on the 4th transition.
- **Glitch rejection:** a 3-cycle glitch on `enc1a` with `DEBOUNCE_CYCLES`=4 → no strobe, no err.
- **Illegal transition:** step enc1 00→11 in one cycle → one `p1_err` pulse, no strobe, accumulator 0. A following 11→01 → one `p1_up` (`STEP_DIV`=1).
- **Simultaneous events and `reset_game`:** forward steps on enc1 and reverse steps on enc2 land in the same cycle → `p1_up` and `p2_dn` are high together. Repeat with `reset_game` held high → all outputs stay 0.
- **Asynchronous reset and no-debounce build:** assert `reset` mid-sequence → outputs 0 in the same cycle. Rebuild without `ENC_DEBOUNCE_EN` → strobe latency exactly 3 edges.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and helpers for the paddle encoder front end.
// Quadrature order (forward): 00 -> 10 -> 11 -> 01 -> 00.
package pong_pkg;

  typedef logic [1:0] quad_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2,
    DIR_ERR  = 2'd3
  } dir_t;

  function automatic quad_t fwd_next(input quad_t q);
    quad_t n;
    unique case (q)
      2'b00:   n = 2'b10;
      2'b10:   n = 2'b11;
      2'b11:   n = 2'b01;
      default: n = 2'b00;
    endcase
    return n;
  endfunction

  function automatic dir_t decode(input quad_t prev,
                                  input quad_t cur);
    dir_t d;
    if (cur == prev)
      d = DIR_NONE;
    else if (cur == fwd_next(prev))
      d = DIR_UP;
    else if (prev == fwd_next(cur))
      d = DIR_DN;
    else
      d = DIR_ERR;
    return d;
  endfunction

  function automatic bit step_div_ok(input int d);
    return (d == 1) || (d == 2) || (d == 4);
  endfunction

endpackage

// File: rtl/quad_channel.sv
// One encoder pair: sync, optional debounce (ENC_DEBOUNCE_EN),
// quadrature decode and step accumulator with registered strobes.
module quad_channel
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STEP_DIV        = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  input  logic reset_game,
  output logic up,
  output logic dn,
  output logic err
);

  // an illegal divider degrades to one strobe per transition
  localparam int DIV_I = step_div_ok(STEP_DIV) ? STEP_DIV : 1;
  localparam logic signed [3:0] DIV = 4'(DIV_I);

  quad_t s1;
  quad_t s2;
  quad_t stable;
  quad_t prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {a, b};
      s2 <= s1;
    end
  end

`ifdef ENC_DEBOUNCE_EN
  localparam int DB_N =
    (DEBOUNCE_CYCLES < 2)   ? 2   :
    (DEBOUNCE_CYCLES > 255) ? 255 : DEBOUNCE_CYCLES;
  localparam logic [7:0] LAST = 8'(DB_N - 1);

  logic [1:0][7:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      stable <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 8'd1;
        end
      end
    end
  end
`else
  assign stable = s2;
`endif

  dir_t              dir;
  logic signed [3:0] acc;
  logic signed [3:0] acc_nxt;
  logic              up_nxt;
  logic              dn_nxt;
  logic              err_nxt;

  always_comb begin
    dir     = decode(prev, stable);
    acc_nxt = acc;
    up_nxt  = 1'b0;
    dn_nxt  = 1'b0;
    err_nxt = 1'b0;
    unique case (dir)
      DIR_UP:  acc_nxt = acc + 4'sd1;
      DIR_DN:  acc_nxt = acc - 4'sd1;
      DIR_ERR: begin
        acc_nxt = '0;
        err_nxt = 1'b1;
      end
      default: ;
    endcase
    if (acc_nxt == DIV) begin
      up_nxt  = 1'b1;
      acc_nxt = '0;
    end else if (acc_nxt == -DIV) begin
      dn_nxt  = 1'b1;
      acc_nxt = '0;
    end
    // prev keeps tracking so release of reset_game is silent
    if (reset_game) begin
      acc_nxt = '0;
      up_nxt  = 1'b0;
      dn_nxt  = 1'b0;
      err_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= '0;
      acc  <= '0;
      up   <= 1'b0;
      dn   <= 1'b0;
      err  <= 1'b0;
    end else begin
      prev <= stable;
      acc  <= acc_nxt;
      up   <= up_nxt;
      dn   <= dn_nxt;
      err  <= err_nxt;
    end
  end

endmodule

// File: rtl/quad_encoder_decoder.sv
// Two-player paddle encoder front end; debounce via ENC_DEBOUNCE_EN.
// Emits one-cycle up/dn/err strobes per player on clk.
module quad_encoder_decoder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STEP_DIV        = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enc1a,
  input  logic enc1b,
  input  logic enc2a,
  input  logic enc2b,
  input  logic reset_game,
  output logic p1_up,
  output logic p1_dn,
  output logic p2_up,
  output logic p2_dn,
  output logic p1_err,
  output logic p2_err
);

  quad_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .STEP_DIV       (STEP_DIV)
  ) u_p1 (
    .clk       (clk),
    .reset     (reset),
    .a         (enc1a),
    .b         (enc1b),
    .reset_game(reset_game),
    .up        (p1_up),
    .dn        (p1_dn),
    .err       (p1_err)
  );

  quad_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .STEP_DIV       (STEP_DIV)
  ) u_p2 (
    .clk       (clk),
    .reset     (reset),
    .a         (enc2a),
    .b         (enc2b),
    .reset_game(reset_game),
    .up        (p2_up),
    .dn        (p2_dn),
    .err       (p2_err)
  );

endmodule

// File: tb/tb_quad_encoder_decoder.sv
// Bench for quad_encoder_decoder: two instances (STEP_DIV 1 and 4)
// checked every cycle against a pin-history model plus directed literals.
module tb_quad_encoder_decoder;

  localparam int D = 4;
`ifdef ENC_DEBOUNCE_EN
  localparam int L   = D + 3;
  localparam bit DEB = 1'b1;
`else
  localparam int L   = 3;
  localparam bit DEB = 1'b0;
`endif
  localparam int B1U = 5;
  localparam int B1D = 4;
  localparam int B2U = 3;
  localparam int B2D = 2;
  localparam int B1E = 1;
  localparam int B2E = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enc1a = 1'b0;
  logic enc1b = 1'b0;
  logic enc2a = 1'b0;
  logic enc2b = 1'b0;
  logic reset_game = 1'b0;
  logic [1:0][5:0] outv;

  int total = 0;
  int bad = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  quad_encoder_decoder #(.DEBOUNCE_CYCLES(D), .STEP_DIV(1)) u_d1 (
    .clk(clk), .reset(reset),
    .enc1a(enc1a), .enc1b(enc1b), .enc2a(enc2a), .enc2b(enc2b),
    .reset_game(reset_game),
    .p1_up(outv[0][B1U]), .p1_dn(outv[0][B1D]),
    .p2_up(outv[0][B2U]), .p2_dn(outv[0][B2D]),
    .p1_err(outv[0][B1E]), .p2_err(outv[0][B2E])
  );

  quad_encoder_decoder #(.DEBOUNCE_CYCLES(D), .STEP_DIV(4)) u_d4 (
    .clk(clk), .reset(reset),
    .enc1a(enc1a), .enc1b(enc1b), .enc2a(enc2a), .enc2b(enc2b),
    .reset_game(reset_game),
    .p1_up(outv[1][B1U]), .p1_dn(outv[1][B1D]),
    .p2_up(outv[1][B2U]), .p2_dn(outv[1][B2D]),
    .p1_err(outv[1][B1E]), .p2_err(outv[1][B2E])
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // ---------------- model ----------------
  logic [3:0] hist[$];
  logic [1:0][1:0] mdeb;
  logic [1:0][1:0] mprev;
  logic [1:0][5:0] mexp;
  int macc[2][2];
  int sd[2] = '{1, 4};
  int md;
  int nn;
  bit mu, mdn, me, flip;
  logic [1:0] nd;
  logic [3:0] smp;

  function automatic int gidx(input logic [1:0] q);
    case (q)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [3:0] samp_at(input int k);
    if (k < 0 || k >= hist.size()) return 4'b0;
    return hist[k];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hist.delete();
      mdeb = '0;
      mprev = '0;
      mexp = '0;
      for (int i = 0; i < 2; i++)
        for (int c = 0; c < 2; c++) macc[i][c] = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        for (int c = 0; c < 2; c++) begin
          mu = 0; mdn = 0; me = 0;
          if (reset_game) begin
            macc[i][c] = 0;
          end else begin
            md = (gidx(mdeb[c]) - gidx(mprev[c]) + 4) % 4;
            if (md == 1) macc[i][c]++;
            else if (md == 3) macc[i][c]--;
            else if (md == 2) begin
              macc[i][c] = 0;
              me = 1;
            end
            if (macc[i][c] == sd[i]) begin
              mu = 1; macc[i][c] = 0;
            end else if (macc[i][c] == -sd[i]) begin
              mdn = 1; macc[i][c] = 0;
            end
          end
          mexp[i][5 - 2*c] = mu;
          mexp[i][4 - 2*c] = mdn;
          mexp[i][1 - c]   = me;
        end
      end
      hist.push_back({enc1a, enc1b, enc2a, enc2b});
      nn = hist.size();
      for (int c = 0; c < 2; c++) begin
        nd = mdeb[c];
        for (int bt = 0; bt < 2; bt++) begin
          if (!DEB) begin
            smp = samp_at(nn - 2);
            nd[bt] = smp[(1-c)*2 + bt];
          end else begin
            // accept a level once D successive samples disagree
            flip = 1;
            for (int j = nn - D - 2; j <= nn - 3; j++) begin
              smp = samp_at(j);
              if (smp[(1-c)*2 + bt] == mdeb[c][bt]) flip = 0;
            end
            if (flip) nd[bt] = ~mdeb[c][bt];
          end
        end
        mprev[c] = mdeb[c];
        mdeb[c] = nd;
      end
    end
  end

  string onm[6] = '{"p2_err", "p1_err", "p2_dn", "p2_up", "p1_dn", "p1_up"};

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < 6; k++)
          chk($sformatf("cyc d%0d %s", i, onm[k]),
              (outv[i][k] === 1'b1) ? 1 : ((outv[i][k] === 1'b0) ? 0 : 2),
              int'(mexp[i][k]));
    end
  end

  // ---------------- stimulus ----------------
  int cnt[2][6];
  int cboth;
  int first_up;

  task automatic run(input int n);
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 6; k++) cnt[i][k] = 0;
    cboth = 0;
    first_up = 0;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < 6; k++)
          if (outv[i][k] === 1'b1) cnt[i][k]++;
      if (outv[0][B1U] && outv[0][B2D]) cboth++;
      if (outv[0][B1U] && first_up == 0) first_up = c;
    end
  endtask

  logic [1:0] fw[4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0] rv[4] = '{2'b01, 2'b11, 2'b10, 2'b00};
  int t0, t1, t2, t3;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    started = 1'b1;
    chk("reset d1 outputs", int'(outv[0]), 0);
    chk("reset d4 outputs", int'(outv[1]), 0);
    reset = 1'b0;
    run(5);

    t0 = 0; t1 = 0; t2 = 0;
    for (int s = 0; s < 4; s++) begin
      {enc1a, enc1b} = fw[s];
      run(10);
      chk($sformatf("fwd latency step%0d", s), first_up, L);
      t0 += cnt[0][B1U];
      t1 += cnt[0][B1D];
      t2 += cnt[1][B1U];
    end
    chk("fwd p1_up count", t0, 4);
    chk("fwd p1_dn count", t1, 0);
    chk("fwd div4 p1_up count", t2, 1);

    t0 = 0; t1 = 0;
    for (int s = 0; s < 4; s++) begin
      {enc2a, enc2b} = rv[s];
      run(10);
      if (s < 3) t1 += cnt[1][B2D];
      else chk("rev div4 dn on 4th", cnt[1][B2D], 1);
      t0 += cnt[0][B2D];
    end
    chk("rev div4 dn early", t1, 0);
    chk("rev d1 p2_dn count", t0, 4);

    enc1a = 1'b1;
    run(3);
    t0 = cnt[0][B1U] + cnt[0][B1D] + cnt[0][B1E];
    enc1a = 1'b0;
    run(12);
    t0 += cnt[0][B1U] + cnt[0][B1D] + cnt[0][B1E];
    chk("glitch events", t0, DEB ? 0 : 2);

    {enc1a, enc1b} = 2'b11;
    run(15);
    chk("illegal err", cnt[0][B1E], 1);
    chk("illegal strobes", cnt[0][B1U] + cnt[0][B1D], 0);
    {enc1a, enc1b} = 2'b01;
    run(15);
    chk("post-illegal up", cnt[0][B1U], 1);
    chk("post-illegal err", cnt[0][B1E], 0);

    {enc1a, enc1b} = 2'b00;
    {enc2a, enc2b} = 2'b01;
    run(15);
    chk("simultaneous up+dn", cboth, 1);

    reset_game = 1'b1;
    {enc1a, enc1b} = 2'b10;
    {enc2a, enc2b} = 2'b11;
    run(15);
    t3 = 0;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 6; k++) t3 += cnt[i][k];
    chk("reset_game events", t3, 0);
    reset_game = 1'b0;
    run(10);
    t3 = 0;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 6; k++) t3 += cnt[i][k];
    chk("reset_game release events", t3, 0);

    {enc1a, enc1b} = 2'b11;
    run(L);
    chk("pre-reset p1_up", int'(outv[0][B1U]), 1);
    reset = 1'b1;
    #1;
    chk("async reset d1", int'(outv[0]), 0);
    chk("async reset d4", int'(outv[1]), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run(20);
    chk("post-reset p1_err", cnt[0][B1E], 1);
    chk("post-reset p2_err", cnt[0][B2E], 1);
    chk("post-reset strobes",
        cnt[0][B1U] + cnt[0][B1D] + cnt[0][B2U] + cnt[0][B2D], 0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
